hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL use a single clock and a synchronous, active-high reset: clk (posedge) and rst (active-high, sampled on the posedge only); no other clock or async path.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 validD, reg_wrD, ldD, use_rs1D, use_rs2D  in  1 each  Decode-stage instruction: valid, writes rd, is a load, reads rs1, reads rs2.
REQ-005 rs1D, rs2D, rdD  in  5 each  Decode-stage register indices.
REQ-006 pc_srcE  in  1  branch/jump taken in EX; redirect this cycle.
REQ-007 ex_busy  in  1  multi-cycle EX operation not complete; EX holds its instruction.
REQ-008 fwdAE, fwdBE  out  2 each  srcA/srcB forwarding select: 00 register file, 01 resultM, 10 resultW; 11 never driven.
REQ-009 stallF, stallD  out  1 each  hold PC / IF-ID register.
REQ-010 stallE  out  1  hold ID-EX register (asserted with ex_busy).
REQ-011 flushD, flushE, flushM  out  1 each  bubble into ID, EX, MEM pipeline registers.
REQ-012 stall_cnt, flush_cnt  out  16 each  saturating perf counters.

Function
REQ-013 SHALL hold shadow E, M, W slots, each {valid, reg_wr, ld, rd, rs1, rs2, use_rs1, use_rs2}, all registered on clk.
REQ-014 Per edge, normal case: D->E, E->M, M->W; each slot captures the slot before it.
REQ-015 flushE or load-use stall: E slot SHALL capture valid=0 (bubble).
REQ-016 ex_busy=1: F, D, E slots hold, M captures bubble, W captures old M.
REQ-017 fwdAE SHALL be 01 if M.valid & M.reg_wr & M.rd!=0 & M.rd==E.rs1 & E.use_rs1 & !M.ld; else 10 if the same test passes on W (ld allowed); else 00. fwdBE is identical on rs2.
REQ-018 Priority: MEM match beats WB match for the same register.
REQ-019 Load-use: E.valid & E.ld & E.rd!=0 & ((use_rs1D & rs1D==E.rd) | (use_rs2D & rs2D==E.rd)) & validD. This asserts stallF=stallD=flushE=1 for exactly one cycle; the consumer reaches E two edges later with fwd=10.
REQ-020 Load in M matching E (WB forward not yet possible) SHALL not occur by construction; the unit need not handle it.
REQ-021 Redirect: pc_srcE=1 SHALL assert flushD=flushE=1 and force stallF=stallD=0, overriding load-use.
REQ-022 ex_busy=1 SHALL assert stallF=stallD=stallE=flushM=1 and SHALL suppress flushD/flushE, including under pc_srcE; pc_srcE is honoured only in the cycle ex_busy=0.
REQ-023 All stall/flush/fwd outputs SHALL be combinational from the shadow slots and the D/E inputs, valid in the same cycle.
REQ-024 stall_cnt SHALL increment once per cycle in which stallD=1; flush_cnt SHALL increment once per cycle in which flushD|flushE=1. Both saturate at 16'hFFFF.

Reset
REQ-025 While rst=1: fwdAE=fwdBE=00, all stall/flush outputs 0.
REQ-026 At the rst edge: all shadow valid=0 and counters=0; other slot fields are don't-care.
REQ-027 rst asserted mid-stall or mid-busy SHALL clear in one edge; there is no carry-over of pending stall.

Verification
REQ-028 add x5 followed by sub x6,x5,x1: cycle sub in E -> fwdAE=01, fwdBE=00, no stall.
REQ-029 lw x7 followed by add x8,x7,x7 -> one cycle stallF=stallD=flushE=1, stall_cnt=1; next-next cycle fwdAE=fwdBE=10.
REQ-030 lw x7 with pc_srcE=1 in the same cycle -> flushD=flushE=1, stallD=0, flush_cnt+1.
REQ-031 Writes to x0 in M and W with consumer reading x0 -> fwdAE=fwdBE=00.
REQ-032 M.rd=W.rd=x3, consumer reads x3 -> fwdAE=01.
REQ-033 ex_busy held 3 cycles -> stallF/D/E=1 and flushM=1 for 3 cycles, stall_cnt=3; rst asserted in the 2nd cycle -> all outputs 0 and counters 0 on the next edge.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Decode/execute hazard handshake between the pipeline and hazard_unit.
// The pipeline is the master; the hazard unit answers with stalls, flushes and fwd selects.
interface hazard_unit_if;
    logic        validD;
    logic        reg_wrD;
    logic        ldD;
    logic        use_rs1D;
    logic        use_rs2D;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rdD;
    logic        pc_srcE;
    logic        ex_busy;
    logic [1:0]  fwdAE;
    logic [1:0]  fwdBE;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output validD, reg_wrD, ldD, use_rs1D, use_rs2D,
        output rs1D, rs2D, rdD, pc_srcE, ex_busy,
        input  fwdAE, fwdBE, stallF, stallD, stallE,
        input  flushD, flushE, flushM, stall_cnt, flush_cnt
    );

    modport slave (
        input  validD, reg_wrD, ldD, use_rs1D, use_rs2D,
        input  rs1D, rs2D, rdD, pc_srcE, ex_busy,
        output fwdAE, fwdBE, stallF, stallD, stallE,
        output flushD, flushE, flushM, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit: shadows E/M/W register usage to drive forwarding,
// load-use stalls, redirect flushes and multi-cycle EX holds.
module hazard_unit (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);
    typedef struct packed {
        logic       valid;
        logic       regWr;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       useRs1;
        logic       useRs2;
    } slot_t;

    slot_t       slotD;
    slot_t       slotE;
    slot_t       slotM;
    slot_t       slotW;
    logic        loadUse;
    logic [1:0]  fwdA;
    logic [1:0]  fwdB;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
    logic        unusedSlotBits;

    // A load still in M cannot forward; that case is excluded by the load-use stall.
    function automatic logic [1:0] fwdSel(
        input slot_t      m,
        input slot_t      w,
        input logic [4:0] rs,
        input logic       useRs
    );
        if (useRs && m.valid && m.regWr && !m.ld &&
            m.rd != 5'd0 && m.rd == rs)
            return 2'b01;
        if (useRs && w.valid && w.regWr &&
            w.rd != 5'd0 && w.rd == rs)
            return 2'b10;
        return 2'b00;
    endfunction

    assign slotD = '{
        valid:  hz.validD,
        regWr:  hz.reg_wrD,
        ld:     hz.ldD,
        rd:     hz.rdD,
        rs1:    hz.rs1D,
        rs2:    hz.rs2D,
        useRs1: hz.use_rs1D,
        useRs2: hz.use_rs2D
    };

    assign loadUse = hz.validD && slotE.valid && slotE.ld &&
                     slotE.rd != 5'd0 &&
                     ((hz.use_rs1D && hz.rs1D == slotE.rd) ||
                      (hz.use_rs2D && hz.rs2D == slotE.rd));

    always_comb begin
        fwdA   = 2'b00;
        fwdB   = 2'b00;
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (!rst) begin
            fwdA = fwdSel(slotM, slotW, slotE.rs1, slotE.useRs1);
            fwdB = fwdSel(slotM, slotW, slotE.rs2, slotE.useRs2);
            // Busy EX owns the pipe; a redirect waits until it finishes.
            if (hz.ex_busy) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (hz.pc_srcE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (loadUse) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slotE    <= '0;
            slotM    <= '0;
            slotW    <= '0;
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!hz.ex_busy)
                slotE <= flushE ? '0 : slotD;
            slotM <= hz.ex_busy ? '0 : slotE;
            slotW <= slotM;
            if (stallD && stallCnt != 16'hFFFF)
                stallCnt <= stallCnt + 16'd1;
            if ((flushD || flushE) && flushCnt != 16'hFFFF)
                flushCnt <= flushCnt + 16'd1;
        end
    end

    assign unusedSlotBits = ^{slotE.regWr,
                              slotM.rs1, slotM.rs2,
                              slotM.useRs1, slotM.useRs2,
                              slotW.ld, slotW.rs1, slotW.rs2,
                              slotW.useRs1, slotW.useRs2};

    assign hz.fwdAE     = fwdA;
    assign hz.fwdBE     = fwdB;
    assign hz.stallF    = stallF;
    assign hz.stallD    = stallD;
    assign hz.stallE    = stallE;
    assign hz.flushD    = flushD;
    assign hz.flushE    = flushE;
    assign hz.flushM    = flushM;
    assign hz.stall_cnt = stallCnt;
    assign hz.flush_cnt = flushCnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, redirect,
// busy hold, reset behaviour and counter saturation.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nVec = 0;
    int   nBad = 0;

    hazard_unit_if hz ();

    hazard_unit dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    // {fwdAE, fwdBE, stallF, stallD, stallE, flushD, flushE, flushM}
    wire [9:0] outs = {hz.fwdAE, hz.fwdBE, hz.stallF, hz.stallD,
                       hz.stallE, hz.flushD, hz.flushE, hz.flushM};

    task automatic drv(
        input logic v, input logic wr, input logic ld,
        input logic u1, input logic u2,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic [4:0] rd
    );
        hz.validD   = v;
        hz.reg_wrD  = wr;
        hz.ldD      = ld;
        hz.use_rs1D = u1;
        hz.use_rs2D = u2;
        hz.rs1D     = r1;
        hz.rs2D     = r2;
        hz.rdD      = rd;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        hz.pc_srcE = 1'b0;
        hz.ex_busy = 1'b0;
        nop();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        hz.pc_srcE = 1'b1;
        hz.ex_busy = 1'b1;
        drv(1, 1, 1, 1, 1, 5'd7, 5'd7, 5'd7);
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL reset_outs: got %b want %b", outs, 10'b0);
        end
        tick();
        tick();
        nVec++;
        if ({hz.stall_cnt, hz.flush_cnt} !== 32'd0) begin
            nBad++;
            $display("FAIL reset_cnt: got %h/%h want 0/0",
                     hz.stall_cnt, hz.flush_cnt);
        end
        hz.pc_srcE = 1'b0;
        hz.ex_busy = 1'b0;
        nop();
        rst = 1'b0;
    endtask

    task automatic test_fwd_mem();
        doReset();
        drv(1, 1, 0, 1, 1, 5'd1, 5'd2, 5'd5);
        tick();
        drv(1, 1, 0, 1, 1, 5'd5, 5'd1, 5'd6);
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL alu_no_stall: got %b want %b", outs, 10'b0);
        end
        tick();
        nop();
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0100_000000) begin
            nBad++;
            $display("FAIL fwd_mem: got %b want %b", outs, 10'b0100_000000);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        drv(1, 1, 1, 1, 0, 5'd2, 5'd0, 5'd7);
        tick();
        drv(1, 1, 0, 1, 1, 5'd7, 5'd7, 5'd8);
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0000_110010) begin
            nBad++;
            $display("FAIL lu_stall: got %b want %b", outs, 10'b0000_110010);
        end
        tick();
        nVec++;
        if (hz.stall_cnt !== 16'd1 || hz.flush_cnt !== 16'd1) begin
            nBad++;
            $display("FAIL lu_cnt: got %0d/%0d want 1/1",
                     hz.stall_cnt, hz.flush_cnt);
        end
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL lu_bubble: got %b want %b", outs, 10'b0);
        end
        tick();
        nop();
        @(negedge clk);
        nVec++;
        if (outs !== 10'b1010_000000) begin
            nBad++;
            $display("FAIL lu_fwd_wb: got %b want %b", outs, 10'b1010_000000);
        end
        tick();
    endtask

    task automatic test_redirect();
        doReset();
        drv(1, 1, 1, 1, 0, 5'd2, 5'd0, 5'd7);
        tick();
        drv(1, 1, 0, 1, 1, 5'd7, 5'd7, 5'd8);
        hz.pc_srcE = 1'b1;
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0000_000110) begin
            nBad++;
            $display("FAIL redirect: got %b want %b", outs, 10'b0000_000110);
        end
        tick();
        hz.pc_srcE = 1'b0;
        nop();
        nVec++;
        if (hz.flush_cnt !== 16'd1 || hz.stall_cnt !== 16'd0) begin
            nBad++;
            $display("FAIL redirect_cnt: got %0d/%0d want 1/0",
                     hz.flush_cnt, hz.stall_cnt);
        end
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL redirect_bubble: got %b want %b", outs, 10'b0);
        end
        tick();
    endtask

    task automatic test_x0();
        doReset();
        drv(1, 1, 0, 1, 0, 5'd1, 5'd0, 5'd0);
        tick();
        drv(1, 1, 0, 1, 0, 5'd2, 5'd0, 5'd0);
        tick();
        drv(1, 1, 0, 1, 1, 5'd0, 5'd0, 5'd9);
        tick();
        nop();
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL x0_no_fwd: got %b want %b", outs, 10'b0);
        end
        tick();
    endtask

    task automatic test_priority();
        doReset();
        drv(1, 1, 0, 1, 0, 5'd1, 5'd0, 5'd3);
        tick();
        drv(1, 1, 0, 1, 0, 5'd2, 5'd0, 5'd3);
        tick();
        drv(1, 1, 0, 1, 1, 5'd3, 5'd3, 5'd10);
        tick();
        drv(1, 1, 0, 1, 0, 5'd3, 5'd3, 5'd11);
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0101_000000) begin
            nBad++;
            $display("FAIL mem_over_wb: got %b want %b", outs, 10'b0101_000000);
        end
        tick();
        nop();
        @(negedge clk);
        nVec++;
        if (outs !== 10'b1000_000000) begin
            nBad++;
            $display("FAIL wb_only: got %b want %b", outs, 10'b1000_000000);
        end
        tick();
    endtask

    task automatic test_busy();
        doReset();
        drv(1, 1, 0, 1, 1, 5'd1, 5'd2, 5'd5);
        tick();
        drv(1, 1, 0, 1, 1, 5'd5, 5'd1, 5'd6);
        hz.ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hz.pc_srcE = (i == 1);
            @(negedge clk);
            nVec++;
            if (outs !== 10'b0000_111001) begin
                nBad++;
                $display("FAIL busy_c%0d: got %b want %b",
                         i, outs, 10'b0000_111001);
            end
            tick();
        end
        hz.ex_busy = 1'b0;
        hz.pc_srcE = 1'b0;
        nVec++;
        if (hz.stall_cnt !== 16'd3 || hz.flush_cnt !== 16'd0) begin
            nBad++;
            $display("FAIL busy_cnt: got %0d/%0d want 3/0",
                     hz.stall_cnt, hz.flush_cnt);
        end
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL busy_release: got %b want %b", outs, 10'b0);
        end
        tick();
        nop();
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0100_000000) begin
            nBad++;
            $display("FAIL busy_hold_fwd: got %b want %b",
                     outs, 10'b0100_000000);
        end
        tick();
        hz.ex_busy = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL rst_mid_busy: got %b want %b", outs, 10'b0);
        end
        tick();
        rst        = 1'b0;
        hz.ex_busy = 1'b0;
        nVec++;
        if ({hz.stall_cnt, hz.flush_cnt} !== 32'd0) begin
            nBad++;
            $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0",
                     hz.stall_cnt, hz.flush_cnt);
        end
        @(negedge clk);
        nVec++;
        if (outs !== 10'b0) begin
            nBad++;
            $display("FAIL rst_no_carry: got %b want %b", outs, 10'b0);
        end
        tick();
    endtask

    task automatic test_saturate();
        doReset();
        hz.ex_busy = 1'b1;
        repeat (65537) tick();
        hz.ex_busy = 1'b0;
        nVec++;
        if (hz.stall_cnt !== 16'hFFFF) begin
            nBad++;
            $display("FAIL stall_sat: got %h want %h", hz.stall_cnt, 16'hFFFF);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_load_use();
        test_redirect();
        test_x0();
        test_priority();
        test_busy();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
